// File: rtl/rr_weighted_arbiter.sv
// rr_weighted_arbiter: N-way round-robin arbiter with per-requester grant quanta.
// Define ARB_LOCK_EN to add the lock port that lets the owner hold past its quantum.
module rr_weighted_arbiter #(
    parameter int N        = 8,
    parameter int WEIGHT_W = 4,
    parameter int ID_W     = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*WEIGHT_W-1:0] weight,
`ifdef ARB_LOCK_EN
    input  logic                  lock,
`endif
    output logic [N-1:0]          grant_out,
    output logic                  grant_valid,
    output logic [ID_W-1:0]       grant_id
);
    logic [ID_W-1:0]     ptr, owner, win, ptr_n, owner_n;
    logic [WEIGHT_W-1:0] cnt, cnt_n, wq, q;
    logic                valid_n, found, held, lk;

`ifdef ARB_LOCK_EN
    assign lk = lock;
`else
    assign lk = 1'b0;
`endif

    // Scan downward so the last hit is the first set bit at or after ptr.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                win   = ID_W'((int'(ptr) + i) % N);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        wq      = weight[int'(owner)*WEIGHT_W +: WEIGHT_W];
        q       = (wq == '0) ? WEIGHT_W'(1) : wq;
        held    = grant_valid & req[owner] & ((cnt < q) | lk);
        valid_n = held | found;
        cnt_n   = held ? ((cnt < q) ? cnt + 1'b1 : cnt) : (found ? WEIGHT_W'(1) : '0);
        owner_n = (held | ~found) ? owner : win;
        ptr_n   = (held | ~found) ? ptr : ((win == ID_W'(N - 1)) ? '0 : win + 1'b1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            grant_valid <= 1'b0;
        end else begin
            ptr         <= ptr_n;
            owner       <= owner_n;
            cnt         <= cnt_n;
            grant_valid <= valid_n;
        end
    end

    assign grant_out = grant_valid ? (N'(1) << owner) : '0;
    assign grant_id  = grant_valid ? owner : '0;
endmodule

// File: tb/tb_rr_weighted_arbiter.sv
// tb_rr_weighted_arbiter: directed and randomized checks against a quantum/rotation model.
module tb_rr_weighted_arbiter;
    localparam int N = 8;
    localparam int W = 4;

    logic         clk = 0;
    logic         rst = 1;
    logic [N-1:0] req = '0;
    logic [31:0]  weight = 32'h1111_1111;
`ifdef ARB_LOCK_EN
    logic         lock = 0;
`endif
    logic [N-1:0] grant_out;
    logic         grant_valid;
    logic [2:0]   grant_id;

    int tests = 0;
    int fails = 0;

    int m_valid, m_owner, m_used, m_ptr;

    rr_weighted_arbiter #(.N(N), .WEIGHT_W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .weight(weight),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .grant_out(grant_out), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_owner = 0; m_used = 0; m_ptr = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".grant"}, 32'(grant_out), m_valid ? (32'd1 << m_owner) : 32'd0);
        chk({tag, ".valid"}, 32'(grant_valid), 32'(m_valid));
        chk({tag, ".id"}, 32'(grant_id), m_valid ? 32'(m_owner) : 32'd0);
    endtask

    // Advance the model by one clock using the rules, then check the DUT after the edge.
    task automatic step(input string tag);
        int  quantum, winner, idx;
        bit  lk, keep;
`ifdef ARB_LOCK_EN
        lk = lock;
`else
        lk = 0;
`endif
        quantum = int'(weight[m_owner*W +: W]);
        if (quantum == 0) quantum = 1;
        keep = m_valid != 0 && req[m_owner] && (m_used < quantum || lk);
        if (keep) begin
            if (m_used < quantum) m_used++;
        end else begin
            winner = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (winner < 0 && req[idx]) winner = idx;
            end
            if (winner < 0) begin
                m_valid = 0; m_used = 0;
            end else begin
                m_valid = 1; m_owner = winner; m_used = 1; m_ptr = (winner + 1) % N;
            end
        end
        @(posedge clk); #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1;
        model_clear();
        @(posedge clk); #1;
        check_model("rst");
        rst = 0;
    endtask

    initial begin
        // Reset and first grant
        req = 8'hFE; weight = 32'h1111_1111;
        @(posedge clk); #1;
        chk("rst.grant0", 32'(grant_out), 0);
        model_clear();
        @(posedge clk); #1;
        chk("rst.grant1", 32'(grant_out), 0);
        chk("rst.valid", 32'(grant_valid), 0);
        rst = 0;
        step("first");
        chk("first.grant", 32'(grant_out), 32'h02);
        chk("first.id", 32'(grant_id), 1);

        // Plain rotation
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step("rot");
            chk("rot.seq", 32'(grant_id), 32'(i % 8));
        end

        // Weighted share 3:1
        do_reset();
        weight = 32'h0010_3000; req = 8'h28;
        for (int i = 0; i < 12; i++) begin
            step("wt");
            chk("wt.seq", 32'(grant_id), (i % 4 == 3) ? 5 : 3);
        end

        // Early release and idle
        do_reset();
        weight = 32'h1111_1411; req = 8'h44;
        step("early.a");
        step("early.b");
        chk("early.own", 32'(grant_id), 2);
        req = 8'h40;
        step("early.hand");
        chk("early.hand40", 32'(grant_out), 32'h40);
        req = 8'h00;
        step("early.idle");
        chk("early.idle0", 32'(grant_out), 0);
        chk("early.idlev", 32'(grant_valid), 0);

`ifdef ARB_LOCK_EN
        do_reset();
        weight = 32'h1111_1121; req = 8'h02;
        step("lock.a");
        req = 8'h03; lock = 1;
        for (int i = 0; i < 5; i++) begin
            step("lock.hold");
            chk("lock.id1", 32'(grant_id), 1);
        end
        lock = 0;
        step("lock.rel");
        chk("lock.id0", 32'(grant_id), 0);
`endif

        // Asynchronous reset in the middle of a grant
        do_reset();
        weight = 32'h1111_1111; req = 8'h10;
        step("ar.a");
        chk("ar.g10", 32'(grant_out), 32'h10);
        #2 rst = 1;
        #1;
        chk("ar.clr", 32'(grant_out), 0);
        chk("ar.clrv", 32'(grant_valid), 0);
        model_clear();
        req = 8'h16;
        @(posedge clk); #2 rst = 0;
        step("ar.b");
        chk("ar.low", 32'(grant_out), 32'h02);

        // Randomized traffic with occasional weight changes
        for (int b = 0; b < 6; b++) begin
            weight = $urandom;
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(9) < 3) req = N'($urandom);
                else if ($urandom_range(19) == 0) req = '0;
`ifdef ARB_LOCK_EN
                lock = ($urandom_range(3) == 0);
`endif
                step("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
